// File: rtl/camera_sequencer.sv
// OV7670 camera path controller: power-up, SCCB init with timeout, settling-frame skip,
// then frame-gated capture into a two-buffer ping-pong store with consumer handshake.
module camera_sequencer #(
   parameter int PWR_UP_CYCLES = 100000,
   parameter int INIT_TIMEOUT  = 2000000,
   parameter int SKIP_FRAMES   = 2,
   parameter int FCNT_W        = 16
) (
   input  logic              iclk,
   input  logic              ireset,
   input  logic              ienable,
   input  logic              iinit_done,
   input  logic              ivsync_s,
   input  logic              irelease,
   output logic              opwdn,
   output logic              oinit_start,
   output logic              ocap_en,
   output logic              obuf_sel,
   output logic              ord_sel,
   output logic              oframe_ready,
   output logic              odrop,
   output logic              oerror,
   output logic [FCNT_W-1:0] oframe_cnt,
   output logic [2:0]        ostate
);

   typedef enum logic [2:0] {
      IDLE      = 3'd0,
      PWR_UP    = 3'd1,
      INIT      = 3'd2,
      INIT_WAIT = 3'd3,
      SETTLE    = 3'd4,
      CAPTURE   = 3'd5,
      ERROR     = 3'd6
   } state_t;

   localparam int CNT_MAX = (PWR_UP_CYCLES > INIT_TIMEOUT) ? PWR_UP_CYCLES : INIT_TIMEOUT;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] PWR_LAST  = CNT_W'(PWR_UP_CYCLES - 1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_TIMEOUT - 1);
   localparam int SKIP_W = $clog2(SKIP_FRAMES + 2);
   localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP_FRAMES > 0) ? SKIP_FRAMES - 1 : 0);

   state_t            state;
   logic [CNT_W-1:0]  cyc_cnt;
   logic [SKIP_W-1:0] skip_cnt;
   logic              vsync_p1;
   logic [1:0]        full;
   logic              wr_sel;
   logic              rd_sel;
   logic              vs_rise;
   logic              vs_fall;

   assign vs_rise  = ivsync_s & ~vsync_p1;
   assign vs_fall  = ~ivsync_s & vsync_p1;
   assign ostate   = state;
   assign obuf_sel = wr_sel;
   assign ord_sel  = rd_sel;

   always_ff @(posedge iclk or negedge ireset) begin
      if (!ireset) begin
         state        <= IDLE;
         cyc_cnt      <= '0;
         skip_cnt     <= '0;
         vsync_p1     <= 1'b0;
         full         <= 2'b00;
         wr_sel       <= 1'b0;
         rd_sel       <= 1'b0;
         opwdn        <= 1'b1;
         oinit_start  <= 1'b0;
         ocap_en      <= 1'b0;
         oframe_ready <= 1'b0;
         odrop        <= 1'b0;
         oerror       <= 1'b0;
         oframe_cnt   <= '0;
      end else begin
         vsync_p1     <= ivsync_s;
         oinit_start  <= 1'b0;
         oframe_ready <= 1'b0;
         odrop        <= 1'b0;
         if (!ienable) begin
            // Abandon everything, including any partially captured frame.
            state      <= IDLE;
            cyc_cnt    <= '0;
            skip_cnt   <= '0;
            full       <= 2'b00;
            wr_sel     <= 1'b0;
            rd_sel     <= 1'b0;
            opwdn      <= 1'b1;
            ocap_en    <= 1'b0;
            oerror     <= 1'b0;
            oframe_cnt <= '0;
         end else begin
            case (state)
               IDLE: begin
                  state   <= PWR_UP;
                  opwdn   <= 1'b0;
                  cyc_cnt <= '0;
               end
               PWR_UP: begin
                  if (cyc_cnt == PWR_LAST) begin
                     state       <= INIT;
                     oinit_start <= 1'b1;
                  end else begin
                     cyc_cnt <= cyc_cnt + 1'b1;
                  end
               end
               INIT: begin
                  state   <= INIT_WAIT;
                  cyc_cnt <= '0;
               end
               INIT_WAIT: begin
                  if (iinit_done) begin
                     state    <= SETTLE;
                     skip_cnt <= '0;
                  end else if (cyc_cnt == INIT_LAST) begin
                     state  <= ERROR;
                     oerror <= 1'b1;
                     opwdn  <= 1'b1;
                  end else begin
                     cyc_cnt <= cyc_cnt + 1'b1;
                  end
               end
               SETTLE: begin
                  if (SKIP_FRAMES == 0) begin
                     state <= CAPTURE;
                  end else if (vs_rise) begin
                     if (skip_cnt == SKIP_LAST) state <= CAPTURE;
                     else                       skip_cnt <= skip_cnt + 1'b1;
                  end
               end
               CAPTURE: begin
                  // Fullness is sampled before this cycle's release lands.
                  if (vs_fall) begin
                     if (!full[wr_sel]) ocap_en <= 1'b1;
                     else               odrop   <= 1'b1;
                  end
                  if (vs_rise && ocap_en) begin
                     ocap_en      <= 1'b0;
                     full[wr_sel] <= 1'b1;
                     wr_sel       <= ~wr_sel;
                     oframe_cnt   <= oframe_cnt + 1'b1;
                     oframe_ready <= 1'b1;
                  end
                  if (irelease && full[rd_sel]) begin
                     full[rd_sel] <= 1'b0;
                     rd_sel       <= ~rd_sel;
                  end
               end
               ERROR: begin
                  oerror  <= 1'b1;
                  opwdn   <= 1'b1;
                  ocap_en <= 1'b0;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule
